regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter INIT_VALUE, default 16'h0000, value written to r0..r7 by the post-reset sweep.
REQ-002 Parameter INIT_EN, default 1, 1 = perform post-reset sweep, 0 = go directly to ARB.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 A_REQ  input  1  requester A (core datapath) write request.
REQ-006 A_DR  input  3  requester A destination register.
REQ-007 A_DATA  input  16  requester A write data.
REQ-008 A_GNT  output  1  requester A grant, combinational, valid in the cycle its request is accepted.
REQ-009 B_REQ, B_DR[2:0], B_DATA[15:0], B_GNT  same roles for requester B (debug/loader port).
REQ-010 BUS  output  16  registered write data to REGFILE BUS.
REQ-011 DR  output  3  registered destination select to REGFILE DR.
REQ-012 LD_REG  output  1  registered write strobe to REGFILE LD_REG.
REQ-013 BUSY  output  1  high while the init sweep runs.

Function
REQ-014 The block SHALL implement states INIT and ARB; after reset it SHALL enter INIT if INIT_EN=1, else ARB.
REQ-015 INIT: on 8 consecutive cycles it SHALL register LD_REG=1, BUS=INIT_VALUE, DR=0,1,...,7 via a 3-bit sweep counter, then enter ARB on the cycle after DR=7 is issued.
REQ-016 BUSY SHALL be 1 in every INIT cycle and 0 in ARB; A_GNT and B_GNT SHALL be 0 throughout INIT.
REQ-017 ARB: A_GNT/B_GNT SHALL be decoded combinationally from current A_REQ, B_REQ and the round-robin pointer; at most one grant high per cycle.
REQ-018 Single requester: whenever exactly one REQ is high, that requester SHALL be granted the same cycle, including every cycle of a back-to-back stream.
REQ-019 Both requesting: the requester not granted most recently SHALL win; pointer SHALL update only on a grant.
REQ-020 Pointer reset value SHALL favour A (A wins first contention after reset).
REQ-021 On the rising edge ending a grant cycle, BUS/DR/LD_REG SHALL register the winner's DATA/DR with LD_REG=1; REGFILE loads on the following edge (write visible two edges after GNT cycle start).
REQ-022 In any cycle with no grant (and not INIT) the next registered LD_REG SHALL be 0; BUS and DR SHALL hold their last values.
REQ-023 Handshake: requester SHALL hold REQ, DR, DATA stable until it samples GNT=1; the edge ending the GNT cycle completes the transfer; REQ still high after that edge is a new request.
REQ-024 A requester deasserting REQ before grant SHALL produce no write and no pointer change.
REQ-025 Simultaneous requests to the same DR: only the winner is written that cycle; loser SHALL be written on its later grant (last writer wins).
REQ-026 Loser wait under continuous contention SHALL not exceed 1 cycle (strict alternation).

Reset
REQ-027 RESET=1 SHALL immediately force LD_REG=0, BUS=16'h0000, DR=3'b000, BUSY=0, grants=0, sweep counter=0, pointer to favour A, independent of CLK.
REQ-028 On RESET deassertion the state SHALL be INIT (INIT_EN=1) with BUSY=1 from that point; first sweep write issues on the first rising edge after release.
REQ-029 RESET asserted mid-sweep or mid-transfer SHALL abort it; an in-flight registered write SHALL be dropped (LD_REG forced 0) and the sweep SHALL restart from DR=0.

Verification
REQ-030 Release reset, INIT_VALUE=16'hA5A5, hold A_REQ=1 -> 8 cycles LD_REG=1, DR 0..7, BUS=A5A5, BUSY=1, A_GNT=0; then A_GNT=1 on 9th cycle.
REQ-031 ARB, A_REQ only, DR=3, DATA=16'h1234 for 1 cycle -> A_GNT=1 that cycle, next cycle LD_REG=1, DR=3, BUS=1234, then LD_REG=0.
REQ-032 Both REQ held 4 cycles after reset-sweep, distinct data -> grants A,B,A,B; registered writes follow in same order one cycle later.
REQ-033 A and B both DR=5, A=16'h0001, B=16'h0002, simultaneous -> A written first, B next cycle; r5 final = 16'h0002.
REQ-034 Assert RESET during sweep at DR=4 -> LD_REG drops to 0 asynchronously; after release sweep restarts at DR=0 for 8 full cycles.
REQ-035 B_REQ pulsed 1 cycle while A holds grant priority and A_REQ high -> B not granted, no B write, pointer unchanged (A next grant still follows A-favour rule only on contention).

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// Two requesters (A: core datapath, B: debug/loader) share one register-file
// write port. Grants are decoded combinationally from the current requests and
// a round-robin pointer. The winner's DR/DATA are registered onto DR/BUS with
// LD_REG=1. After reset, an optional sweep writes INIT_VALUE into r0..r7.
module regfile_write_arbiter #(
   parameter logic [15:0] INIT_VALUE = 16'h0000,
   parameter bit          INIT_EN    = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        A_REQ,
   input  logic [2:0]  A_DR,
   input  logic [15:0] A_DATA,
   output logic        A_GNT,
   input  logic        B_REQ,
   input  logic [2:0]  B_DR,
   input  logic [15:0] B_DATA,
   output logic        B_GNT,
   output logic [15:0] BUS,
   output logic [2:0]  DR,
   output logic        LD_REG,
   output logic        BUSY
);

   typedef enum logic {S_INIT = 1'b0, S_ARB = 1'b1} state_t;

   // Without a sweep, reset drops straight into arbitration.
   localparam state_t RST_STATE = INIT_EN ? S_INIT : S_ARB;

   state_t     state;
   logic [2:0] sweep_cnt;
   // favor_a=1: A wins the next contention. It flips only on a grant.
   logic       favor_a;
   logic       arb_en;

   // Grants are forced low while reset is asserted, so they drop immediately.
   assign arb_en = (state == S_ARB) && !RESET;
   assign BUSY   = (state == S_INIT) && !RESET;

   // Round-robin grant decode. A lone requester always wins.
   always_comb begin
      A_GNT = 1'b0;
      B_GNT = 1'b0;
      if (arb_en) begin
         if (A_REQ && (!B_REQ || favor_a))
            A_GNT = 1'b1;
         else if (B_REQ)
            B_GNT = 1'b1;
      end
   end

   // Sweep/arbitration FSM with registered write-port outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= RST_STATE;
         sweep_cnt <= 3'd0;
         favor_a   <= 1'b1;
         LD_REG    <= 1'b0;
         BUS       <= 16'h0000;
         DR        <= 3'b000;
      end else begin
         case (state)
            S_INIT: begin
               LD_REG    <= 1'b1;
               BUS       <= INIT_VALUE;
               DR        <= sweep_cnt;
               sweep_cnt <= sweep_cnt + 3'd1;
               if (sweep_cnt == 3'd7)
                  state <= S_ARB;
            end
            default: begin
               // With no grant, BUS/DR keep their last values.
               LD_REG <= A_GNT | B_GNT;
               if (A_GNT) begin
                  BUS     <= A_DATA;
                  DR      <= A_DR;
                  favor_a <= 1'b0;
               end else if (B_GNT) begin
                  BUS     <= B_DATA;
                  DR      <= B_DR;
                  favor_a <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// The stimulus side models the spec rules: the sweep, plus "lone requester
// wins; on contention the one not granted last wins". It checks grants and
// BUSY, and it queues the write expected on the next edge. The monitor side
// pops the queue each cycle and compares LD_REG/DR/BUS.
module tb_regfile_write_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        A_REQ = 1'b0, B_REQ = 1'b0;
   logic [2:0]  A_DR = '0, B_DR = '0;
   logic [15:0] A_DATA = '0, B_DATA = '0;
   logic        A_GNT, B_GNT, LD_REG, BUSY;
   logic [15:0] BUS;
   logic [2:0]  DR;

   localparam logic [15:0] IV = 16'hA5A5;

   regfile_write_arbiter #(.INIT_VALUE(IV), .INIT_EN(1'b1)) dut (
      .CLK(CLK), .RESET(RESET),
      .A_REQ(A_REQ), .A_DR(A_DR), .A_DATA(A_DATA), .A_GNT(A_GNT),
      .B_REQ(B_REQ), .B_DR(B_DR), .B_DATA(B_DATA), .B_GNT(B_GNT),
      .BUS(BUS), .DR(DR), .LD_REG(LD_REG), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0]  dr;
      logic [15:0] data;
   } wr_t;

   wr_t         expq[$];
   int          checks = 0;
   int          failures = 0;

   // Reference model state: spec-level view.
   bit          m_init;
   int          m_cnt;
   bit          m_favor_a;
   logic [15:0] last_bus = '0;
   logic [2:0]  last_dr = '0;
   logic [15:0] dut_rf [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_wr(input logic [2:0] d, input logic [15:0] v);
      wr_t e;
      e.dr = d;
      e.data = v;
      expq.push_back(e);
   endtask

   // One cycle of the reference model, evaluated after inputs settle.
   task automatic model_cycle(output int win);
      win = 0;
      chk("busy", BUSY, m_init);
      if (m_init) begin
         chk("a_gnt_init", A_GNT, 0);
         chk("b_gnt_init", B_GNT, 0);
         push_wr(3'(m_cnt), IV);
         m_cnt++;
         if (m_cnt == 8) m_init = 0;
      end else begin
         if (A_REQ && B_REQ) win = m_favor_a ? 1 : 2;
         else if (A_REQ)     win = 1;
         else if (B_REQ)     win = 2;
         chk("a_gnt", A_GNT, win == 1);
         chk("b_gnt", B_GNT, win == 2);
         if (win == 1) begin push_wr(A_DR, A_DATA); m_favor_a = 0; end
         if (win == 2) begin push_wr(B_DR, B_DATA); m_favor_a = 1; end
      end
   endtask

   task automatic step(input logic aq, input logic [2:0] adr, input logic [15:0] ad,
                       input logic bq, input logic [2:0] bdr, input logic [15:0] bd,
                       output int win);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      A_REQ = aq; A_DR = adr; A_DATA = ad;
      B_REQ = bq; B_DR = bdr; B_DATA = bd;
      #3;
      model_cycle(win);
   endtask

   task automatic do_reset(input bit inflight);
      @(posedge CLK);
      #1;
      if (inflight) begin
         chk("pre_rst_ld", LD_REG, 1);
         chk("pre_rst_dr", DR, 4);
      end
      RESET = 1'b1;
      A_REQ = 1'b0;
      B_REQ = 1'b0;
      expq.delete();
      m_init = 1;
      m_cnt = 0;
      m_favor_a = 1;
      last_bus = '0;
      last_dr = '0;
      #1;
      chk("rst_async_ld", LD_REG, 0);
      chk("rst_async_bus", BUS, 0);
      chk("rst_async_dr", DR, 0);
      chk("rst_async_busy", BUSY, 0);
      repeat (2) @(posedge CLK);
   endtask

   // Monitor: compare registered write-port outputs against the queue.
   initial begin
      wr_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (RESET) begin
            chk("rst_ld", LD_REG, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_gnt", {A_GNT, B_GNT}, 0);
         end else begin
            if (LD_REG === 1'b1) dut_rf[DR] = BUS;
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("wr_ld", LD_REG, 1);
               chk("wr_dr", DR, e.dr);
               chk("wr_bus", BUS, e.data);
               last_bus = e.data;
               last_dr = e.dr;
            end else begin
               chk("idle_ld", LD_REG, 0);
               chk("hold_dr", DR, last_dr);
               chk("hold_bus", BUS, last_bus);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      logic ar, br;
      logic [2:0] adr, bdr;
      logic [15:0] ad, bd;
      RESET = 1'b1;
      do_reset(0);

      // Sweep with A held high. The first A grant comes on the 9th cycle.
      repeat (8) step(1, 3'd1, 16'h1111, 0, 3'd0, 16'h0, w);
      step(1, 3'd1, 16'h1111, 0, 3'd0, 16'h0, w);
      chk("a_first_after_sweep", w, 1);

      // Single-cycle A request.
      step(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, w);
      step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);
      step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);

      // Reset in mid-sweep while the DR=4 write is in flight.
      do_reset(0);
      repeat (5) step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);
      do_reset(1);
      repeat (8) step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);

      // Continuous contention alternates A,B,A,B.
      for (int i = 0; i < 4; i++)
         step(1, 3'(i), 16'hA000 + 16'(i), 1, 3'(i + 4), 16'hB000 + 16'(i), w);

      // Same destination register: A then B. The last writer wins.
      step(1, 3'd5, 16'h0001, 1, 3'd5, 16'h0002, w);
      chk("same_dr_first", w, 1);
      step(0, 3'd0, 16'h0, 1, 3'd5, 16'h0002, w);
      chk("same_dr_second", w, 2);
      step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);
      step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);
      chk("r5_final", dut_rf[5], 16'h0002);

      // One-cycle B pulse while A is favoured and requesting: B loses.
      step(1, 3'd2, 16'h2222, 1, 3'd6, 16'h6666, w);
      step(1, 3'd2, 16'h2223, 0, 3'd6, 16'h6666, w);
      step(1, 3'd2, 16'h2224, 1, 3'd7, 16'h7777, w);
      step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);

      // Randomised traffic with the hold-until-grant handshake and occasional withdrawal.
      ar = 0; br = 0; adr = 0; bdr = 0; ad = 0; bd = 0; w = 0;
      for (int i = 0; i < 400; i++) begin
         if (w == 1 || !ar) begin
            ar = ($urandom_range(0, 2) != 0);
            adr = 3'($urandom);
            ad = 16'($urandom);
         end else if ($urandom_range(0, 7) == 0) ar = 0;
         if (w == 2 || !br) begin
            br = ($urandom_range(0, 2) != 0);
            bdr = 3'($urandom);
            bd = 16'($urandom);
         end else if ($urandom_range(0, 7) == 0) br = 0;
         step(ar, adr, ad, br, bdr, bd, w);
      end
      repeat (3) step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, w);
      chk("queue_drained", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
